asphalt_usb_ctl_pio: RTL

Avalon-MM output PIO that drives the USB controller's control pins (chip reset, wake, etc.) from the Nios II CPU. It is the write-direction counterpart of the USB status input ports. Alongside plain data/set/clear registers, it has a hardware pulse engine. The engine inverts selected bits for an exact cycle count, so the USB chip reset width does not depend on software timing.

---
 rtl/asphalt_usb_ctl_pkg.sv | 14 +
 rtl/asphalt_pulse_timer.sv | 38 +++
 rtl/asphalt_usb_ctl_pio.sv | 85 ++++++++
 3 files changed

// File: rtl/asphalt_usb_ctl_pkg.sv
// Shared register offsets and PULSE register field positions for the USB control PIO.
// No logic; constants only.
package asphalt_usb_ctl_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  localparam int CNT_LSB  = 0;
  localparam int CNT_W    = 16;
  localparam int MASK_LSB = 16;

endpackage

// File: rtl/asphalt_pulse_timer.sv
// Loadable 16-bit down-counter: load takes effect at the edge, busy while remaining != 0.
// Latency: remaining updates one edge after load; no backpressure.
module asphalt_pulse_timer
  import asphalt_usb_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A reload wins over the decrement on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign remaining = cnt_q;

endmodule

// File: rtl/asphalt_usb_ctl_pio.sv
// Avalon-MM output PIO for USB controller pins: DATA/SET/CLEAR registers plus a hardware pulse engine.
// Writes take effect at the write edge; readdata is registered (latency 1); never stalls the bus.
module asphalt_usb_ctl_pio
  import asphalt_usb_ctl_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             pulse_load;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             unused_wdata;

  assign wr_en      = chipselect & ~write_n;
  assign pulse_load = wr_en && (address == ADDR_PULSE);

  // Upper writedata bits have no destination.
  assign unused_wdata = ^writedata;

  asphalt_pulse_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (pulse_load),
    .len       (writedata[CNT_LSB +: CNT_W]),
    .busy      (busy),
    .remaining (remaining)
  );

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  data_d = writedata[WIDTH-1:0];
        ADDR_SET:   data_d = data_q | writedata[WIDTH-1:0];
        ADDR_CLR:   data_d = data_q & ~writedata[WIDTH-1:0];
        ADDR_PULSE: mask_d = writedata[MASK_LSB +: WIDTH];
        default:    ;
      endcase
    end
  end

  // Read mux samples pre-write state, so a same-edge read/write returns the old value.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
      ADDR_PULSE: begin
        readdata_d[CNT_LSB +: CNT_W]   = remaining;
        readdata_d[MASK_LSB +: WIDTH]  = mask_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ (busy ? mask_q : '0);

endmodule
